vga_horiz_fsm: RTL



---
 rtl/vga_horiz_fsm.sv | 106 ++++++++++
 1 files changed

// File: rtl/vga_horiz_fsm.sv
`timescale 1ns/1ps
// Purpose: horizontal VGA timing. Generates hsync, a frame-buffer X fetch address that leads the
//          visible window by FETCH_LEAD clocks, the visible-pixel window and a line-end strobe.
// Latency: every output is registered, one clock after the counter value it decodes. No backpressure (free-running).
//
// Ports:
//   clk          pixel clock (25 MHz for 640x480@60)
//   reset        synchronous, active-high; counter, state and outputs return to their idle values
//   vga_hs       HSYNC, active-low pulse of HS_PULSE clocks at the start of each line
//   addr_x_valid addr_x holds a fetch column this cycle
//   addr_x       column to fetch, 0..PIXELS-1, 0 when not valid
//   pixel_active visible window; pixel data fetched FETCH_LEAD cycles ago is presented now
//   line_end     one-cycle strobe on the last clock of each line
module vga_horiz_fsm #(
    parameter int HS_PULSE     = 96,
    parameter int BACK_PORCH   = 48,
    parameter int PIXELS       = 640,
    parameter int FRONT_PORCH  = 16,
    parameter int ADDR_X_WIDTH = 10,
    parameter int FETCH_LEAD   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    vga_hs,
    output logic                    addr_x_valid,
    output logic [ADDR_X_WIDTH-1:0] addr_x,
    output logic                    pixel_active,
    output logic                    line_end
);

    localparam int LINE  = HS_PULSE + BACK_PORCH + PIXELS + FRONT_PORCH;
    localparam int CNT_W = $clog2(LINE);

    // Last count of each phase; the FSM leaves a phase on these values.
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(HS_PULSE - 1);
    localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(HS_PULSE + BACK_PORCH - 1);
    localparam logic [CNT_W-1:0] PX_LAST   = CNT_W'(HS_PULSE + BACK_PORCH + PIXELS - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE - 1);

    // Visible window and the earlier fetch window. Inclusive bounds avoid
    // overflowing CNT_W when FRONT_PORCH is zero.
    localparam logic [CNT_W-1:0] PX_FIRST = CNT_W'(HS_PULSE + BACK_PORCH);
    localparam logic [CNT_W-1:0] A_FIRST  = CNT_W'(HS_PULSE + BACK_PORCH - FETCH_LEAD);
    localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(HS_PULSE + BACK_PORCH - FETCH_LEAD + PIXELS - 1);

    typedef enum logic [1:0] {
        STATE_HS_PULSE    = 2'd0,
        STATE_BACK_PORCH  = 2'd1,
        STATE_PIXELS      = 2'd2,
        STATE_FRONT_PORCH = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic                    vga_hs_next;
    logic                    addr_x_valid_next;
    logic [ADDR_X_WIDTH-1:0] addr_x_next;
    logic                    pixel_active_next;
    logic                    line_end_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= STATE_HS_PULSE;
            cnt          <= '0;
            vga_hs       <= 1'b1;
            addr_x_valid <= 1'b0;
            addr_x       <= '0;
            pixel_active <= 1'b0;
            line_end     <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            vga_hs       <= vga_hs_next;
            addr_x_valid <= addr_x_valid_next;
            addr_x       <= addr_x_next;
            pixel_active <= pixel_active_next;
            line_end     <= line_end_next;
        end
    end

    always_comb begin
        state_next        = state;
        cnt_next          = (cnt == LINE_LAST) ? '0 : cnt + CNT_W'(1);
        vga_hs_next       = (state != STATE_HS_PULSE);
        addr_x_valid_next = (cnt >= A_FIRST) && (cnt <= A_LAST);
        pixel_active_next = (cnt >= PX_FIRST) && (cnt <= PX_LAST);
        line_end_next     = (cnt == LINE_LAST);
        // The registered addr_x belongs to the previous count, so inside the
        // fetch window the next column is simply one more; the first column is 0.
        addr_x_next       = '0;
        if (addr_x_valid_next && addr_x_valid) begin
            addr_x_next = addr_x + ADDR_X_WIDTH'(1);
        end

        case (state)
            STATE_HS_PULSE:    if (cnt == HS_LAST)   state_next = STATE_BACK_PORCH;
            STATE_BACK_PORCH:  if (cnt == BP_LAST)   state_next = STATE_PIXELS;
            STATE_PIXELS:      if (cnt == PX_LAST)   state_next = STATE_FRONT_PORCH;
            STATE_FRONT_PORCH: if (cnt == LINE_LAST) state_next = STATE_HS_PULSE;
            default:           state_next = state_t'('x);
        endcase
    end

endmodule
